// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
// Micro-instruction sequencer for the 16-bit ALU datapath. Accepts one
// instruction over a valid/ready handshake, drives the datapath strobes for a
// single issue cycle, waits SETTLE_CYCLES cycles, then pulses done.
//
// Build option: define ALU_SEQ_ILLEGAL_TRAP_EN to trap illegal instructions
// (skip ISSUE/WAIT, no ack, sticky err). Without it, illegal instructions issue
// as a NOP (ack only) and err is tied low.
// -----------------------------------------------------------------------------
module alu_seq_ctrl #(
    parameter int SETTLE_CYCLES = 1,   // 0..15
    parameter int OP_W          = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [1:0]      instr_cmd,
    input  logic [OP_W-1:0] instr_op,
    input  logic            instr_xsel,
    input  logic [1:0]      instr_ysel,
    input  logic [1:0]      instr_dst,
    input  logic [1:0]      instr_src,
    output logic            ack,
    output logic [OP_W-1:0] op_code_alu,
    output logic            aregread,
    output logic            cregread,
    output logic            aoutregread,
    output logic            boutregread,
    output logic            coutregread,
    output logic            aregwrite,
    output logic            bregwrite,
    output logic            cregwrite,
    output logic [1:0]      outregwrite,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_ALU  = 2'b01;
    localparam logic [1:0] CMD_MOVE = 2'b10;

    // Counter reload value on WAIT entry; unused when there is no WAIT phase.
    localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    // Instruction combinations the datapath cannot execute.
    function automatic logic is_illegal(input logic [1:0] cmd,
                                        input logic [1:0] dst,
                                        input logic [1:0] src);
        case (cmd)
            CMD_LOAD: return (dst == 2'b11);
            CMD_ALU:  return (dst == 2'b00);
            CMD_MOVE: return (dst == 2'b11) || (src == 2'b00) ||
                             (dst == 2'b00 && src == 2'b11);   // no Cout->Areg path
            default:  return 1'b1;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      cmd_q, ysel_q, dst_q, src_q;
    logic            xsel_q;
    logic [OP_W-1:0] op_q;
    logic [3:0]      cnt_q;

    logic accept;
    logic in_illegal;
    logic cur_illegal;

    assign accept      = (state_q == ST_IDLE) && instr_valid;
    assign in_illegal  = is_illegal(instr_cmd, instr_dst, instr_src);
    assign cur_illegal = is_illegal(cmd_q, dst_q, src_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path through the case can
        // leave state_d unassigned and infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                    state_d = in_illegal ? ST_DONE : ST_ISSUE;
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: state_d = (SETTLE_CYCLES == 0) ? ST_DONE : ST_WAIT;
            ST_WAIT:  if (cnt_q == 4'd0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Capture instruction fields on the handshake edge; run the settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these few field/counter flops are reset too, so nothing
        // downstream ever decodes X after reset; there is no memory array here.
        if (!rst_n) begin
            cmd_q  <= CMD_LOAD;
            xsel_q <= 1'b0;
            ysel_q <= 2'b00;
            dst_q  <= 2'b00;
            src_q  <= 2'b00;
            op_q   <= '0;
            cnt_q  <= 4'd0;
        end else begin
            if (accept) begin
                cmd_q  <= instr_cmd;
                xsel_q <= instr_xsel;
                ysel_q <= instr_ysel;
                dst_q  <= instr_dst;
                src_q  <= instr_src;
                // op_code_alu only changes for a legal ALU instruction and
                // holds its last value otherwise.
                if (instr_cmd == CMD_ALU && !in_illegal) op_q <= instr_op;
            end
            if (state_q == ST_ISSUE)
                cnt_q <= SETTLE_LOAD;
            else if (state_q == ST_WAIT && cnt_q != 4'd0)
                cnt_q <= cnt_q - 4'd1;
        end
    end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic err_q;

    // Sticky illegal-instruction flag, set on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    err_q <= 1'b0;
        else if (accept && in_illegal) err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Strobe decode: active only in ISSUE, driven from the captured fields.
    always_comb begin
        ack         = 1'b0;
        aregread    = 1'b0;
        cregread    = 1'b0;
        aoutregread = 1'b0;
        boutregread = 1'b0;
        coutregread = 1'b0;
        aregwrite   = 1'b0;
        bregwrite   = 1'b0;
        cregwrite   = 1'b0;
        outregwrite = 2'b00;
        if (state_q == ST_ISSUE) begin
            ack = 1'b1;
            if (!cur_illegal) begin
                case (cmd_q)
                    CMD_LOAD: begin
                        case (dst_q)
                            2'b00:   aregwrite = 1'b1;
                            2'b01:   bregwrite = 1'b1;
                            2'b10:   cregwrite = 1'b1;
                            default: ;
                        endcase
                    end
                    CMD_ALU: begin
                        aregread    = xsel_q;
                        outregwrite = dst_q;
                        case (ysel_q)
                            2'b00: cregread    = 1'b1;
                            2'b01: aoutregread = 1'b1;
                            2'b10: boutregread = 1'b1;
                            2'b11: coutregread = 1'b1;
                        endcase
                    end
                    CMD_MOVE: begin
                        case (dst_q)
                            2'b00:   aregwrite = 1'b1;
                            2'b01:   bregwrite = 1'b1;
                            2'b10:   cregwrite = 1'b1;
                            default: ;
                        endcase
                        case (src_q)
                            2'b01:   aoutregread = 1'b1;
                            2'b10:   boutregread = 1'b1;
                            2'b11:   coutregread = 1'b1;
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign op_code_alu = op_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    // Ready is masked while reset is held so every output reads 0 in reset.
    assign instr_ready = (state_q == ST_IDLE) && rst_n;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Directed, table-driven bench for alu_seq_ctrl (SETTLE_CYCLES = 1). Handles
// both builds of ALU_SEQ_ILLEGAL_TRAP_EN. Outputs are sampled on the falling
// edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;

    localparam int S    = 1;
    localparam int OP_W = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            instr_valid = 1'b0;
    logic            instr_ready;
    logic [1:0]      instr_cmd = 2'b00;
    logic [OP_W-1:0] instr_op = '0;
    logic            instr_xsel = 1'b0;
    logic [1:0]      instr_ysel = 2'b00;
    logic [1:0]      instr_dst = 2'b00;
    logic [1:0]      instr_src = 2'b00;
    logic            ack;
    logic [OP_W-1:0] op_code_alu;
    logic            aregread, cregread;
    logic            aoutregread, boutregread, coutregread;
    logic            aregwrite, bregwrite, cregwrite;
    logic [1:0]      outregwrite;
    logic            busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [OP_W-1:0] last_op   = '0;   // model of the held op code
    logic            err_model = 1'b0; // model of the sticky err flag

    always #5 clk = ~clk;

    alu_seq_ctrl #(.SETTLE_CYCLES(S), .OP_W(OP_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_cmd   (instr_cmd),
        .instr_op    (instr_op),
        .instr_xsel  (instr_xsel),
        .instr_ysel  (instr_ysel),
        .instr_dst   (instr_dst),
        .instr_src   (instr_src),
        .ack         (ack),
        .op_code_alu (op_code_alu),
        .aregread    (aregread),
        .cregread    (cregread),
        .aoutregread (aoutregread),
        .boutregread (boutregread),
        .coutregread (coutregread),
        .aregwrite   (aregwrite),
        .bregwrite   (bregwrite),
        .cregwrite   (cregwrite),
        .outregwrite (outregwrite),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // Strobe bundle: {ack, ar, cr, aor, bor, cor, aw, bw, cw, orw[1:0]}
    logic [10:0] strb;
    assign strb = {ack, aregread, cregread, aoutregread, boutregread, coutregread,
                   aregwrite, bregwrite, cregwrite, outregwrite};

    typedef struct {
        string       name;
        logic [1:0]  cmd;
        logic [3:0]  op;
        logic        xsel;
        logic [1:0]  ysel;
        logic [1:0]  dst;
        logic [1:0]  src;
        logic [10:0] exp_strb;
        logic        illegal;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic [1:0] cmd, input logic [3:0] op,
                                input logic xsel, input logic [1:0] ysel, input logic [1:0] dst,
                                input logic [1:0] src, input logic [10:0] es, input logic ill);
        vec_t v;
        v.name = name; v.cmd = cmd; v.op = op; v.xsel = xsel; v.ysel = ysel;
        v.dst = dst; v.src = src; v.exp_strb = es; v.illegal = ill;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bounded wait (on falling edges) for the controller to become ready.
    task automatic wait_idle(input string name);
        int budget = 0;
        while (instr_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check({name, "_ready"}, 32'(instr_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        wait_idle(v.name);
        instr_cmd  = v.cmd;  instr_op  = v.op;  instr_xsel = v.xsel;
        instr_ysel = v.ysel; instr_dst = v.dst; instr_src  = v.src;
        instr_valid = 1'b1;
        @(negedge clk);                        // cycle N+1
        instr_valid = 1'b0;
        instr_cmd  = ~v.cmd; instr_op = ~v.op; instr_xsel = ~v.xsel;
        instr_ysel = ~v.ysel; instr_dst = ~v.dst; instr_src = ~v.src;
        if (!v.illegal && v.cmd == 2'b01) last_op = v.op;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        if (v.illegal) begin
            err_model = 1'b1;
            check({v.name, "_trap_strb"}, 32'(strb), 32'd0);
            check({v.name, "_trap_done"}, 32'(done), 32'd1);
            check({v.name, "_trap_err"},  32'(err),  32'd1);
            @(negedge clk);
            check({v.name, "_trap_idle"}, 32'({instr_ready, busy, done}), 32'b100);
            return;
        end
`endif
        check({v.name, "_issue_strb"}, 32'(strb), 32'(v.exp_strb));
        check({v.name, "_issue_stat"}, 32'({instr_ready, busy, done}), 32'b010);
        check({v.name, "_issue_err"},  32'(err), 32'(err_model));
        if (!v.illegal) check({v.name, "_issue_op"}, 32'(op_code_alu), 32'(last_op));
        for (int i = 0; i < S; i++) begin
            @(negedge clk);
            check({v.name, "_wait_strb"}, 32'(strb), 32'd0);
            check({v.name, "_wait_stat"}, 32'({instr_ready, busy, done}), 32'b010);
        end
        @(negedge clk);
        check({v.name, "_done_strb"}, 32'(strb), 32'd0);
        check({v.name, "_done_stat"}, 32'({instr_ready, busy, done}), 32'b011);
        check({v.name, "_done_op"},   32'(op_code_alu), 32'(last_op));
        @(negedge clk);
        check({v.name, "_idle_stat"}, 32'({instr_ready, busy, done}), 32'b100);
    endtask

    // Absolute safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        logic seen_done;

        //                name        cmd   op   x  ysel  dst   src   ack_ar_cr_aor_bor_cor_aw_bw_cw_orw  ill
        vecs.push_back(mk("load_a",   2'b00, 4'h0, 0, 2'b00, 2'b00, 2'b00, 11'b1_0_0_000_100_00, 1'b0));
        vecs.push_back(mk("load_b",   2'b00, 4'h0, 0, 2'b00, 2'b01, 2'b00, 11'b1_0_0_000_010_00, 1'b0));
        vecs.push_back(mk("load_c",   2'b00, 4'h0, 0, 2'b00, 2'b10, 2'b00, 11'b1_0_0_000_001_00, 1'b0));
        vecs.push_back(mk("alu_2",    2'b01, 4'h2, 1, 2'b00, 2'b01, 2'b00, 11'b1_1_1_000_000_01, 1'b0));
        vecs.push_back(mk("alu_5",    2'b01, 4'h5, 0, 2'b01, 2'b10, 2'b00, 11'b1_0_0_100_000_10, 1'b0));
        vecs.push_back(mk("alu_a",    2'b01, 4'hA, 1, 2'b10, 2'b11, 2'b00, 11'b1_1_0_010_000_11, 1'b0));
        vecs.push_back(mk("alu_f",    2'b01, 4'hF, 0, 2'b11, 2'b01, 2'b00, 11'b1_0_0_001_000_01, 1'b0));
        vecs.push_back(mk("mov_c_bo", 2'b10, 4'h3, 0, 2'b00, 2'b10, 2'b10, 11'b1_0_0_010_001_00, 1'b0));
        vecs.push_back(mk("mov_a_ao", 2'b10, 4'h0, 0, 2'b00, 2'b00, 2'b01, 11'b1_0_0_100_100_00, 1'b0));
        vecs.push_back(mk("mov_b_co", 2'b10, 4'h0, 0, 2'b00, 2'b01, 2'b11, 11'b1_0_0_001_010_00, 1'b0));
        vecs.push_back(mk("mov_a_bo", 2'b10, 4'h0, 0, 2'b00, 2'b00, 2'b10, 11'b1_0_0_010_100_00, 1'b0));
        vecs.push_back(mk("load_junk",2'b00, 4'h9, 1, 2'b11, 2'b01, 2'b11, 11'b1_0_0_000_010_00, 1'b0));
        vecs.push_back(mk("ill_cmd3", 2'b11, 4'h6, 1, 2'b01, 2'b01, 2'b01, 11'b1_0_0_000_000_00, 1'b1));
        vecs.push_back(mk("ill_alu0", 2'b01, 4'h7, 1, 2'b00, 2'b00, 2'b00, 11'b1_0_0_000_000_00, 1'b1));
        vecs.push_back(mk("ill_mvs0", 2'b10, 4'h0, 0, 2'b00, 2'b01, 2'b00, 11'b1_0_0_000_000_00, 1'b1));
        vecs.push_back(mk("ill_a_co", 2'b10, 4'h0, 0, 2'b00, 2'b00, 2'b11, 11'b1_0_0_000_000_00, 1'b1));
        vecs.push_back(mk("ill_ld_d3",2'b00, 4'h0, 0, 2'b00, 2'b11, 2'b00, 11'b1_0_0_000_000_00, 1'b1));
        vecs.push_back(mk("ill_mv_d3",2'b10, 4'h0, 0, 2'b00, 2'b11, 2'b01, 11'b1_0_0_000_000_00, 1'b1));
        vecs.push_back(mk("mov_c_ao", 2'b10, 4'h0, 0, 2'b00, 2'b10, 2'b01, 11'b1_0_0_100_001_00, 1'b0));

        // Reset state.
        #12;
        check("reset_outputs", 32'({strb, instr_ready, busy, done, err, op_code_alu}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_ready", 32'({instr_ready, busy, done, err}), 32'b1000);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back: valid held high, fields changed while busy.
        wait_idle("b2b");
        instr_cmd = 2'b00; instr_dst = 2'b00; instr_valid = 1'b1;
        @(negedge clk);
        check("b2b_first_strb", 32'(strb), 32'(11'b1_0_0_000_100_00));
        instr_dst = 2'b10;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (ack !== 1'b1 && gap < 20);
        check("b2b_gap", 32'(gap), 32'(3 + S));
        check("b2b_second_strb", 32'(strb), 32'(11'b1_0_0_000_001_00));
        instr_valid = 1'b0;

        // Reset asserted during WAIT.
        wait_idle("rst_mid");
        instr_cmd = 2'b00; instr_dst = 2'b01; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check("rst_mid_issue", 32'(strb), 32'(11'b1_0_0_000_010_00));
        @(negedge clk);
        check("rst_mid_wait_busy", 32'({busy, done}), 32'b10);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", 32'({strb, instr_ready, busy, done, err, op_code_alu}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_op = '0;
        err_model = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1 || ack === 1'b1) seen_done = 1'b1;
        end
        check("rst_mid_no_done", 32'(seen_done), 32'd0);
        run_vec(vecs[0]);
        run_vec(vecs[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Instruction sequencer for the 16-bit ALU datapath (A/B/C operand registers, Aout/Bout/Cout result registers).
- Accepts one micro-instruction at a time over a valid/ready handshake.
- Drives the datapath strobes (ack, op_code_alu, register read/write selects, outregwrite) for exactly one issue cycle, waits a programmable settle time, then pulses done.
- Sits between the program/memory front end and the datapath.

Parameters:
- SETTLE_CYCLES, 1: wait cycles after the issue cycle before done; legal range 0..15.
- OP_W, 4: width of the ALU op code; matches the datapath op_code_alu.

Ports:
- clk  in  1  system clock, all state on the rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  micro-instruction present
- instr_ready  out  1  controller can accept; high only in IDLE
- instr_cmd  in  2  00 LOAD, 01 ALU, 10 MOVE, 11 reserved
- instr_op  in  OP_W  ALU op code (ALU cmd only)
- instr_xsel  in  1  ALU X operand: 1 Areg, 0 Breg
- instr_ysel  in  2  ALU Y operand: 00 Creg, 01 Aout, 10 Bout, 11 Cout
- instr_dst  in  2  LOAD/MOVE dest: 00 A, 01 B, 10 C; ALU dest: 01 Aout, 10 Bout, 11 Cout
- instr_src  in  2  MOVE source: 01 Aout, 10 Bout, 11 Cout
- ack  out  1  datapath sample enable
- op_code_alu  out  OP_W  to datapath
- aregread, cregread  out  1 each  operand selects
- aoutregread, boutregread, coutregread  out  1 each  result-register read selects (one-hot or zero)
- aregwrite, bregwrite, cregwrite  out  1 each  register write enables (one-hot or zero)
- outregwrite  out  2  00 none, 01 Aout, 10 Bout, 11 Cout
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky illegal-instruction flag (only when the optional feature is compiled in; otherwise tied 0)

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE. All strobes, op_code_alu, outregwrite, busy, done and err = 0. instr_ready = 1 once out of reset.
- FSM states:
  - IDLE: instr_ready=1. If instr_valid is high at a clock edge, capture all instr_* fields and go to ISSUE.
  - ISSUE: lasts exactly one cycle. ack=1 and the decoded strobes are driven from registered (captured) fields. Next state is WAIT, or DONE if SETTLE_CYCLES=0.
  - WAIT: all strobes=0, ack=0. A 4-bit down-counter is loaded with SETTLE_CYCLES-1 on entry. When the counter reaches 0, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Latency: handshake at edge N; strobes valid in cycle N+1; done high in cycle N+2+SETTLE_CYCLES; next accept possible at edge N+3+SETTLE_CYCLES.
- Decode in ISSUE:
  - LOAD: aregwrite, bregwrite or cregwrite per instr_dst. All read selects 0, so the datapath takes Mem_Dat_X (A/B) or Mem_Dat_Y (C).
  - ALU: aregread=instr_xsel; cregread=(ysel==00); aoutregread/boutregread/coutregread=(ysel==01/10/11); outregwrite=instr_dst; op_code_alu=instr_op. No register write enables.
  - MOVE: the write enable selected by instr_dst, plus the read select decoded from instr_src. MOVE with dst=A and src=Cout is illegal (the datapath has no Cout->Areg path).
- Outside ISSUE, op_code_alu holds its last value; every other strobe is 0.
- At most one write enable and at most one out-read select are ever high at a time.
- instr_* changes while busy are ignored; fields are captured only on the handshake edge.
- Illegal cases: cmd=11, ALU with dst=00, MOVE with src=00, MOVE A<-Cout, LOAD/MOVE with dst=11. Without the optional feature these issue as a NOP: ack=1, all strobes 0, and the FSM still runs through WAIT and DONE.
- Reset mid-operation immediately returns to IDLE with all outputs at reset values. No partial strobe cycle may follow.

Optional Feature:
- Macro: ALU_SEQ_ILLEGAL_TRAP_EN.
- Defined: an illegal instruction skips ISSUE and WAIT and goes straight to DONE. ack stays 0 and done pulses. err is set the same cycle and stays set until reset.
- Undefined: NOP behaviour as described above; err is tied 0.

Test Plan:
- Reset release then LOAD dst=00 -> instr_ready=1 after reset; cycle N+1 shows ack=1 and aregwrite=1 with all other strobes 0; with SETTLE_CYCLES=1, done is high at N+3.
- ALU op=4'h2, xsel=1, ysel=00, dst=01 -> during ISSUE: aregread=1, cregread=1, outregwrite=01, op_code_alu=2; after the issue cycle: outregwrite=00.
- MOVE dst=10, src=10 -> cregwrite=1 and boutregread=1 for one cycle only; busy is high from N+1 through done.
- instr_valid held high for back-to-back instructions -> each is accepted only in IDLE, with 3+SETTLE_CYCLES cycles between accepts; fields changed while busy have no effect.
- rst_n asserted during WAIT -> all outputs go to 0 asynchronously, no done pulse, and the next instruction is accepted normally.
- cmd=11 -> macro undefined: ack pulse with zero strobes, done later, err=0. Macro defined: no ack, done at N+1, err=1 and sticky.
